// File: rtl/mem_master_ctrl.sv
// mem_master_ctrl: single-word command initiator for the single-port synchronous
// memory, with a two-pass pattern BIST sequencer. Every output is a register:
// the next values are computed in one combinational block and loaded at the clock edge.
module mem_master_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] BIST_PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RSP   = 3'd4;
  localparam logic [2:0] S_B_WR  = 3'd5;
  localparam logic [2:0] S_B_RD  = 3'd6;
  localparam logic [2:0] S_B_END = 3'd7;

  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  // BIST data word for an address: pattern ^ address, inverted in the second pass.
  function automatic logic [DATA_W-1:0] bist_data(input logic pass, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    d = BIST_PATTERN ^ DATA_W'(addr);
    bist_data = pass ? ~d : d;
  endfunction

  logic [2:0]        state_r, state_s;
  logic              phase_r, phase_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic              cmd_ready_r, cmd_ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [ADDR_W-1:0] fail_addr_r, fail_addr_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_wr_en_r, mem_wr_en_s;
  logic              mem_rd_en_r, mem_rd_en_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

  // Expected-data pipeline aligned with the memory read latency.
  logic              pipe_vld_r  [RD_LATENCY];
  logic [ADDR_W-1:0] pipe_addr_r [RD_LATENCY];
  logic [DATA_W-1:0] pipe_exp_r  [RD_LATENCY];

  logic              accept_s;
  logic              cmp_vld_s;
  logic [ADDR_W-1:0] cmp_addr_s;
  logic [DATA_W-1:0] cmp_exp_s;

  assign cmd_ready      = cmd_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign bist_busy      = busy_r;
  assign bist_done      = done_r;
  assign bist_pass      = pass_r;
  assign bist_fail_addr = fail_addr_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wr_en      = mem_wr_en_r;
  assign mem_rd_en      = mem_rd_en_r;
  assign mem_wdata      = mem_wdata_r;

  // Next-state and next-output computation for the command path and BIST sequencer.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    wait_cnt_s  = wait_cnt_r;
    cmd_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    busy_s      = busy_r;
    done_s      = done_r;
    pass_s      = pass_r;
    fail_addr_s = fail_addr_r;
    mem_addr_s  = mem_addr_r;
    mem_wr_en_s = 1'b0;
    mem_rd_en_s = 1'b0;
    mem_wdata_s = mem_wdata_r;
    accept_s    = cmd_valid & cmd_ready_r;
    cmp_vld_s   = pipe_vld_r[RD_LATENCY-1];
    cmp_addr_s  = pipe_addr_r[RD_LATENCY-1];
    cmp_exp_s   = pipe_exp_r[RD_LATENCY-1];

    case (state_r)
      S_IDLE, S_RSP: begin
        if ((state_r == S_IDLE) && bist_start) begin
          // BIST has priority over a simultaneous command.
          state_s     = S_B_WR;
          phase_s     = 1'b0;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          fail_addr_s = ZERO_ADDR;
          mem_wr_en_s = 1'b1;
          mem_addr_s  = ZERO_ADDR;
          mem_wdata_s = bist_data(1'b0, ZERO_ADDR);
        end else if (accept_s) begin
          mem_addr_s = cmd_addr;
          if (cmd_we) begin
            state_s     = S_WR;
            mem_wr_en_s = 1'b1;
            mem_wdata_s = cmd_wdata;
          end else begin
            state_s     = S_RD;
            mem_rd_en_s = 1'b1;
          end
        end else begin
          state_s     = S_IDLE;
          cmd_ready_s = 1'b1;
        end
      end
      S_WR: begin
        state_s     = S_IDLE;
        cmd_ready_s = 1'b1;
      end
      S_RD: begin
        state_s    = S_RWAIT;
        wait_cnt_s = WAIT_W'(RD_LATENCY - 1);
      end
      S_RWAIT: begin
        if (wait_cnt_r == {WAIT_W{1'b0}}) begin
          state_s     = S_RSP;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = mem_rdata;
          cmd_ready_s = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r - WAIT_W'(1);
        end
      end
      S_B_WR: begin
        if (mem_addr_r == LAST_ADDR) begin
          state_s     = S_B_RD;
          mem_rd_en_s = 1'b1;
          mem_addr_s  = ZERO_ADDR;
        end else begin
          mem_wr_en_s = 1'b1;
          mem_addr_s  = mem_addr_r + ADDR_W'(1);
          mem_wdata_s = bist_data(phase_r, mem_addr_r + ADDR_W'(1));
        end
      end
      S_B_RD: begin
        if (cmp_vld_s && (mem_rdata != cmp_exp_s)) begin
          // First miscompare ends the test; reads still in flight are dropped.
          state_s     = S_B_END;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          pass_s      = 1'b0;
          fail_addr_s = cmp_addr_s;
        end else if (cmp_vld_s && (cmp_addr_s == LAST_ADDR)) begin
          if (!phase_r) begin
            state_s     = S_B_WR;
            phase_s     = 1'b1;
            mem_wr_en_s = 1'b1;
            mem_addr_s  = ZERO_ADDR;
            mem_wdata_s = bist_data(1'b1, ZERO_ADDR);
          end else begin
            state_s = S_B_END;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = 1'b1;
          end
        end else if (mem_rd_en_r && (mem_addr_r != LAST_ADDR)) begin
          mem_rd_en_s = 1'b1;
          mem_addr_s  = mem_addr_r + ADDR_W'(1);
        end else begin
          // Read issue finished; wait for the remaining compares.
          state_s = S_B_RD;
        end
      end
      S_B_END: begin
        state_s     = S_IDLE;
        cmd_ready_s = 1'b1;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      phase_r     <= 1'b0;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= ZERO_ADDR;
      mem_addr_r  <= ZERO_ADDR;
      mem_wr_en_r <= 1'b0;
      mem_rd_en_r <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      wait_cnt_r  <= wait_cnt_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_addr_r <= fail_addr_s;
      mem_addr_r  <= mem_addr_s;
      mem_wr_en_r <= mem_wr_en_s;
      mem_rd_en_r <= mem_rd_en_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  // Expected-data pipeline; flushed whenever BIST readback is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < RD_LATENCY; j++) begin
        pipe_vld_r[j]  <= 1'b0;
        pipe_addr_r[j] <= ZERO_ADDR;
        pipe_exp_r[j]  <= {DATA_W{1'b0}};
      end
    end else begin
      pipe_vld_r[0]  <= mem_rd_en_r & (state_r == S_B_RD) & (state_s == S_B_RD);
      pipe_addr_r[0] <= mem_addr_r;
      pipe_exp_r[0]  <= bist_data(phase_r, mem_addr_r);
      for (int j = 1; j < RD_LATENCY; j++) begin
        pipe_vld_r[j]  <= pipe_vld_r[j-1] & (state_s == S_B_RD);
        pipe_addr_r[j] <= pipe_addr_r[j-1];
        pipe_exp_r[j]  <= pipe_exp_r[j-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_master_ctrl.sv
// Directed testbench for mem_master_ctrl with a registered-read memory model.
module tb_mem_master_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [1:0] cmd_addr = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       bist_start = 1'b0;
  logic       bist_busy;
  logic       bist_done;
  logic       bist_pass;
  logic [1:0] bist_fail_addr;
  logic [1:0] mem_addr;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // memory model
  logic [7:0] mem [4];
  logic [7:0] rdata_q = 8'h00;
  logic [1:0] rd_addr_q = 2'd0;
  logic       fault_en = 1'b0;
  logic [9:0] wlog [256];
  int         wcount = 0;
  int         overlap = 0;

  mem_master_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .bist_fail_addr(bist_fail_addr),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = rdata_q | ((fault_en && rd_addr_q == 2'd1) ? 8'h01 : 8'h00);

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      if (wcount < 256) wlog[wcount] <= {mem_addr, mem_wdata};
      wcount <= wcount + 1;
    end
    if (mem_rd_en) begin
      rdata_q   <= mem[mem_addr];
      rd_addr_q <= mem_addr;
    end
  end

  always @(negedge clk) begin
    if (mem_wr_en && mem_rd_en) overlap <= overlap + 1;
  end

  typedef struct packed {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] exp_bist [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one command and checks its cycle-by-cycle behaviour.
  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("vec_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.we) begin
      chk("wr_strobe", mem_wr_en, 1);
      chk("wr_no_rd", mem_rd_en, 0);
      chk("wr_addr", mem_addr, v.addr);
      chk("wr_data", mem_wdata, v.wdata);
      chk("wr_ready_low", cmd_ready, 0);
      @(negedge clk);
      chk("wr_strobe_off", mem_wr_en, 0);
      chk("wr_ready_back", cmd_ready, 1);
    end else begin
      chk("rd_strobe", mem_rd_en, 1);
      chk("rd_no_wr", mem_wr_en, 0);
      chk("rd_addr", mem_addr, v.addr);
      @(negedge clk);
      chk("rd_wait_rsp", rsp_valid, 0);
      chk("rd_strobe_off", mem_rd_en, 0);
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, v.exp);
      chk("rsp_ready", cmd_ready, 1);
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
      chk("rsp_hold", rsp_rdata, v.exp);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bist_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, bist_done, 1);
  endtask

  initial begin
    int base;
    int k;
    logic [7:0] wq [4];

    vecs[0] = '{we: 1'b1, addr: 2'd2, wdata: 8'h3C, exp: 8'h00};
    vecs[1] = '{we: 1'b0, addr: 2'd2, wdata: 8'h00, exp: 8'h3C};
    vecs[2] = '{we: 1'b1, addr: 2'd0, wdata: 8'h11, exp: 8'h00};
    vecs[3] = '{we: 1'b1, addr: 2'd3, wdata: 8'hF0, exp: 8'h00};
    vecs[4] = '{we: 1'b0, addr: 2'd0, wdata: 8'h00, exp: 8'h11};
    vecs[5] = '{we: 1'b0, addr: 2'd3, wdata: 8'h00, exp: 8'hF0};
    vecs[6] = '{we: 1'b1, addr: 2'd2, wdata: 8'hC3, exp: 8'h00};
    vecs[7] = '{we: 1'b0, addr: 2'd2, wdata: 8'h00, exp: 8'hC3};
    exp_bist = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'h5A, 8'h5B, 8'h58, 8'h59};
    wq = '{8'h10, 8'h20, 8'h30, 8'h40};

    // reset values
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst_mem", {mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, 0);
    chk("rst_bist", {bist_busy, bist_done, bist_pass, bist_fail_addr}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", cmd_ready, 1);

    // table-driven single commands
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // back-to-back writes with cmd_valid held
    k = 0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd0; cmd_wdata = wq[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("b2b_wr_en", mem_wr_en, (c % 2 == 0) ? 1 : 0);
      chk("b2b_ready", cmd_ready, (c % 2 == 0) ? 0 : 1);
      chk("b2b_no_rd", mem_rd_en, 0);
      if (mem_wr_en && k < 4) begin
        chk("b2b_addr", mem_addr, k);
        chk("b2b_data", mem_wdata, wq[k]);
        k++;
        if (k < 4) begin
          cmd_addr = 2'(k); cmd_wdata = wq[k];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", k, 4);

    // BIST on healthy memory
    base = wcount;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    chk("bist_busy", bist_busy, 1);
    chk("bist_ready_low", cmd_ready, 0);
    wait_done("bist_done");
    chk("bist_end_busy", bist_busy, 0);
    chk("bist_pass", bist_pass, 1);
    chk("bist_wcount", wcount - base, 8);
    for (int i = 0; i < 8; i++) chk("bist_wlog", wlog[base + i], {2'(i % 4), exp_bist[i]});
    @(negedge clk);
    chk("bist_done_sticky", bist_done, 1);
    chk("bist_idle_ready", cmd_ready, 1);
    chk("bist_mem3", mem[3], 8'h59);

    // BIST with stuck bit at addr 1
    fault_en = 1'b1;
    base = wcount;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    chk("fbist_done_clr", bist_done, 0);
    wait_done("fbist_done");
    chk("fbist_pass", bist_pass, 0);
    chk("fbist_addr", bist_fail_addr, 1);
    chk("fbist_busy", bist_busy, 0);
    repeat (3) @(negedge clk);
    chk("fbist_wcount", wcount - base, 4);
    chk("fbist_mem3", mem[3], 8'hA6);
    fault_en = 1'b0;

    // reset during RWAIT
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rr_rd", mem_rd_en, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_rsp", rsp_valid, 0);
    chk("rr_outs", {cmd_ready, rsp_rdata, mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, 0);
    chk("rr_bist", {bist_busy, bist_done, bist_pass, bist_fail_addr}, 0);
    @(negedge clk);
    chk("rr_ready", cmd_ready, 1);
    chk("rr_rsp2", rsp_valid, 0);
    @(negedge clk);
    chk("rr_rsp3", rsp_valid, 0);

    // BIST and write requested together
    base = wcount;
    bist_start = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'h11;
    @(negedge clk);
    bist_start = 1'b0;
    chk("arb_busy", bist_busy, 1);
    chk("arb_ready", cmd_ready, 0);
    chk("arb_wdata", mem_wdata, 8'hA5);
    wait_done("arb_done");
    chk("arb_pass", bist_pass, 1);
    chk("arb_wcount", wcount - base, 8);
    k = 0;
    while (!(mem_wr_en && mem_wdata == 8'h11) && k < 10) begin
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    chk("arb_wr", mem_wr_en, 1);
    chk("arb_addr", mem_addr, 0);
    @(negedge clk);
    chk("arb_mem0", mem[0], 8'h11);
    chk("arb_mem1", mem[1], 8'h5B);
    chk("arb_total", wcount - base, 9);

    chk("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
